overlap_sched: RTL and testbench
================================

Name: overlap_sched

Overview:
- Channel scheduler for the single overlap datapath in the decoder back-end.
- Arbitrates between two channel sample streams (ch0/ch1) and grants overlap one whole granule at a time (GRANULE_LEN samples).
- Tags each forwarded sample with in_overlap_firstSequence.
- Drives the overlap input handshake through a one-entry registered output stage.

Parameters:
DATA_W, 65, width of a pcmSample word
GRANULE_LEN, 576, samples per granule (18 x 32 subbands); must be >= 2
CNT_W, $clog2(GRANULE_LEN), width of the sample counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
ch0_valid  in  1  channel 0 sample valid
ch0_ready  out  1  channel 0 sample accepted
ch0_pcmSample  in  DATA_W  channel 0 sample
ch1_valid  in  1  channel 1 sample valid
ch1_ready  out  1  channel 1 sample accepted
ch1_pcmSample  in  DATA_W  channel 1 sample
in_overlap_valid  out  1  sample valid toward overlap
in_overlap_ready  in  1  overlap accepts sample
in_overlap_pcmSample  out  DATA_W  sample toward overlap
in_overlap_firstSequence  out  2  bit0 = first sample of granule; bit1 = channel index
grant_ch  out  1  channel currently owning the datapath (valid while busy)
busy  out  1  a granule is in progress
granule_done  out  1  one-cycle pulse when the last sample of a granule is accepted by overlap

Behaviour:
- Reset (reset = 0, asynchronous) drives all of the following:
  - state = ARB, last_served = 1 (so ch0 wins first), count = 0.
  - All outputs 0: in_overlap_valid, ch*_ready, busy, grant_ch, granule_done, in_overlap_pcmSample, in_overlap_firstSequence.
- Reset asserted mid-granule aborts it. Partial samples are discarded and the next granule restarts at count 0 with ch0 priority.
- FSM states:
  - ARB:
    - Only ch0_valid = 1 -> grant ch0.
    - Only ch1_valid = 1 -> grant ch1.
    - Both = 1 -> grant !last_served.
    - None -> stay in ARB.
    - On grant: set grant_ch, busy = 1, count = 0, go to XFER.
    - No sample is accepted in the ARB cycle.
  - XFER:
    - ch<grant_ch>_ready = !in_overlap_valid || in_overlap_ready. The non-granted ready is 0.
    - On accept (granted valid && ready):
      - Load the output register with the sample.
      - in_overlap_firstSequence = {grant_ch, count == 0}; in_overlap_valid = 1 next cycle.
      - count++.
    - Accepting sample GRANULE_LEN-1 marks it last, sets last_served = grant_ch and goes to DRAIN.
  - DRAIN:
    - Hold until overlap accepts the last sample (in_overlap_valid && in_overlap_ready).
    - That cycle: granule_done = 1 (registered, visible next cycle), busy = 0, go to ARB.
- Output register: holds its value while in_overlap_valid && !in_overlap_ready. Data and firstSequence must be stable while valid is high and ready is low.
- Valid drops the cycle after acceptance unless a new sample loads in the same cycle; back-to-back throughput is 1 sample/cycle.
- Latency: channel accept -> in_overlap_valid = 1 cycle.
- Granule switch costs 2 idle cycles minimum (DRAIN and ARB).
- Granules are atomic: a higher-priority channel never preempts an in-progress granule.
- Channel valid dropping mid-granule stalls the scheduler. There is no timeout and the grant is held.
- count wraps to 0 only through ARB, never inside XFER.

Optional Feature:
Macro: OVERLAP_SCHED_STATS_EN
- Defined:
  - Adds outputs stat_gran_ch0 and stat_gran_ch1 (16 bits each): completed-granule counters incremented on granule_done for the owning channel.
  - Counters saturate at 16'hFFFF and are reset to 0.
  - Adds output stat_stall (16 bits): saturating count of XFER cycles with granted valid = 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package overlap_pkg holds:
  - The FSM state enum (ARB, XFER, DRAIN).
  - The firstSequence bit-position constants (FS_FIRST = 0, FS_CH = 1).
  - The default DATA_W and GRANULE_LEN constants, shared with overlap and the bench.
- One sub-module, overlap_sched_outreg: the one-entry valid/ready output register (data + tag). FSM and arbitration stay in the top module.

Test Plan:
- Reset release, ch0_valid continuous with samples 0..575, in_overlap_ready = 1:
  - Sample 0 arrives with firstSequence = 2'b01.
  - Samples 1..575 arrive with 2'b00.
  - granule_done pulses once after sample 575.
  - Throughput 1/cycle.
- ch0 and ch1 both valid continuously from reset:
  - Granule order ch0, ch1, ch0.
  - ch1 samples carry firstSequence bit1 = 1.
  - Exactly 2 idle cycles between granules.
- ch1 raises valid mid ch0 granule (sample 100): ch0 keeps the grant until sample 575; ch1 is granted next.
- in_overlap_ready toggles 1010… during ch0 granule: every sample is delivered exactly once, in order, with data held while stalled.
- Assert reset at ch1 sample 300, release:
  - All outputs 0 during reset.
  - The next grant goes to ch0 when both are valid.
  - The first sample carries firstSequence = 2'b01.
- With OVERLAP_SCHED_STATS_EN, 3 ch0 + 2 ch1 granules, ch0 valid low for 5 cycles once: stat_gran_ch0 = 3, stat_gran_ch1 = 2, stat_stall = 5.

Source files
------------

// File: rtl/overlap_pkg.sv
// Shared FSM encoding, firstSequence bit positions and default sizes for the
// overlap channel scheduler and its bench.
package overlap_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int FS_FIRST = 0;
    localparam int FS_CH    = 1;

    localparam int DEFAULT_DATA_W      = 65;
    localparam int DEFAULT_GRANULE_LEN = 576;

endpackage

// File: rtl/overlap_sched_outreg.sv
// One-entry valid/ready output register toward overlap: holds sample and tag
// while the consumer stalls, reloads in the same cycle it is drained.
module overlap_sched_outreg
    import overlap_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [1:0]        tag_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        tag_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [1:0]        tag_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            tag_q   <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            tag_q   <= tag_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign tag_o   = tag_q;

endmodule

// File: rtl/overlap_sched.sv
// Two-channel granule scheduler feeding the single overlap datapath.
// Optional statistics counters are built when OVERLAP_SCHED_STATS_EN is defined.
module overlap_sched
    import overlap_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int GRANULE_LEN = DEFAULT_GRANULE_LEN,
    parameter int CNT_W       = $clog2(GRANULE_LEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ch0_valid,
    output logic              ch0_ready,
    input  logic [DATA_W-1:0] ch0_pcmSample,
    input  logic              ch1_valid,
    output logic              ch1_ready,
    input  logic [DATA_W-1:0] ch1_pcmSample,
    output logic              in_overlap_valid,
    input  logic              in_overlap_ready,
    output logic [DATA_W-1:0] in_overlap_pcmSample,
    output logic [1:0]        in_overlap_firstSequence,
    output logic              grant_ch,
    output logic              busy,
    output logic              granule_done
`ifdef OVERLAP_SCHED_STATS_EN
    ,
    output logic [15:0]       stat_gran_ch0,
    output logic [15:0]       stat_gran_ch1,
    output logic [15:0]       stat_stall
`endif
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(GRANULE_LEN - 1);

    state_e            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              sel_valid;
    logic              slot_free;
    logic              load;
    logic [DATA_W-1:0] sel_data;
    logic [1:0]        tag_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARB;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        count_d   = count_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        load      = 1'b0;
        ch0_ready = 1'b0;
        ch1_ready = 1'b0;
        sel_valid = grant_q ? ch1_valid : ch0_valid;
        slot_free = !in_overlap_valid || in_overlap_ready;
        unique case (state_q)
            ARB: begin
                if (ch0_valid || ch1_valid) begin
                    // Round-robin only matters on contention; a lone requester always wins.
                    grant_d = (ch0_valid && ch1_valid) ? !last_q : ch1_valid;
                    busy_d  = 1'b1;
                    count_d = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                ch0_ready = !grant_q && slot_free;
                ch1_ready = grant_q && slot_free;
                if (sel_valid && slot_free) begin
                    load    = 1'b1;
                    count_d = count_q + 1'b1;
                    if (count_q == LAST_IDX) begin
                        last_d  = grant_q;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (in_overlap_valid && in_overlap_ready) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        sel_data         = grant_q ? ch1_pcmSample : ch0_pcmSample;
        tag_in           = '0;
        tag_in[FS_CH]    = grant_q;
        tag_in[FS_FIRST] = (count_q == '0);
    end

    overlap_sched_outreg #(
        .DATA_W (DATA_W)
    ) u_outreg (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load),
        .data_i  (sel_data),
        .tag_i   (tag_in),
        .ready_i (in_overlap_ready),
        .valid_o (in_overlap_valid),
        .data_o  (in_overlap_pcmSample),
        .tag_o   (in_overlap_firstSequence)
    );

    assign grant_ch     = grant_q;
    assign busy         = busy_q;
    assign granule_done = done_q;

`ifdef OVERLAP_SCHED_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] gran0_q, gran1_q, stall_q;

    // Counters update on the same edge that raises granule_done, so they are
    // already current while the pulse is visible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gran0_q <= '0;
            gran1_q <= '0;
            stall_q <= '0;
        end else begin
            if (done_d && !grant_q) gran0_q <= sat_inc(gran0_q);
            if (done_d && grant_q)  gran1_q <= sat_inc(gran1_q);
            if (state_q == XFER && !sel_valid) stall_q <= sat_inc(stall_q);
        end
    end

    assign stat_gran_ch0 = gran0_q;
    assign stat_gran_ch1 = gran1_q;
    assign stat_stall    = stall_q;
`endif

endmodule

// File: tb/tb_overlap_sched.sv
// Directed bench for overlap_sched with a granule-level scoreboard model.
module tb_overlap_sched;
    import overlap_pkg::*;

    localparam int DW = DEFAULT_DATA_W;
    localparam int GL = DEFAULT_GRANULE_LEN;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ch0_valid = 1'b0, ch1_valid = 1'b0, in_overlap_ready = 1'b0;
    logic [DW-1:0] ch0_pcmSample = '0, ch1_pcmSample = '0;
    logic          ch0_ready, ch1_ready, in_overlap_valid;
    logic [DW-1:0] in_overlap_pcmSample;
    logic [1:0]    in_overlap_firstSequence;
    logic          grant_ch, busy, granule_done;
`ifdef OVERLAP_SCHED_STATS_EN
    logic [15:0]   stat_gran_ch0, stat_gran_ch1, stat_stall;
`endif

    overlap_sched dut (
        .clk                      (clk),
        .reset                    (reset),
        .ch0_valid                (ch0_valid),
        .ch0_ready                (ch0_ready),
        .ch0_pcmSample            (ch0_pcmSample),
        .ch1_valid                (ch1_valid),
        .ch1_ready                (ch1_ready),
        .ch1_pcmSample            (ch1_pcmSample),
        .in_overlap_valid         (in_overlap_valid),
        .in_overlap_ready         (in_overlap_ready),
        .in_overlap_pcmSample     (in_overlap_pcmSample),
        .in_overlap_firstSequence (in_overlap_firstSequence),
        .grant_ch                 (grant_ch),
        .busy                     (busy),
        .granule_done             (granule_done)
`ifdef OVERLAP_SCHED_STATS_EN
        ,
        .stat_gran_ch0            (stat_gran_ch0),
        .stat_gran_ch1            (stat_gran_ch1),
        .stat_stall               (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Stimulus controls, written by the main sequence only.
    bit en[2];
    int lim[2];
    int rdy_mode;
    bit chk_gap, chk_tput, drop_req;

    // Source state, written by the driver only.
    int sent[2];
    int drop_left;
    bit drop_taken;

    // Scoreboard model, written by the compare process only.
    int mcnt[2];
    int m_idx, mcur, mlast, gran, beats, done_seen, last_end, first_cyc;
    bit done_pend, hold_pend;
    logic [DW-1:0] held_d;
    logic [1:0]    held_t;
    int ord[$];
    int ftag[$];

    function automatic logic [DW-1:0] data_fn(input int c, input int n);
        logic [31:0] lo, mid;
        lo  = 32'(n);
        mid = 32'(n * 7 + 3) ^ 32'hA5A5_0000;
        return {c[0], mid, lo};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int code_of(input int q[$]);
        int c = 0;
        foreach (q[i]) c = c * 10 + q[i];
        return c;
    endfunction

    // Source driver: a channel's word advances only after it was accepted.
    initial begin
        bit h0, h1;
        forever begin
            @(negedge clk);
            h0 = ch0_valid && ch0_ready;
            h1 = ch1_valid && ch1_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (!reset) begin
                sent[0] = 0;
                sent[1] = 0;
                drop_left = 0;
                drop_taken = 0;
            end else begin
                if (h0) sent[0]++;
                if (h1) sent[1]++;
                if (drop_req && !drop_taken) begin
                    drop_left = 5;
                    drop_taken = 1;
                end else if (drop_left > 0) begin
                    drop_left--;
                end
            end
            ch0_valid        = en[0] && (sent[0] < lim[0]) && (drop_left == 0);
            ch0_pcmSample    = data_fn(0, sent[0]);
            ch1_valid        = en[1] && (sent[1] < lim[1]);
            ch1_pcmSample    = data_fn(1, sent[1]);
            in_overlap_ready = (rdy_mode == 0) ? 1'b1 : cyc[0];
        end
    end

    // Compare process: predicts every overlap beat from the arbitration rules.
    always @(negedge clk) begin : cmp
        logic [1:0] et;
        bit a0, a1;
        if (!reset) begin
            chk("rst_valid", in_overlap_valid, 0);
            chk("rst_ch0_ready", ch0_ready, 0);
            chk("rst_ch1_ready", ch1_ready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_grant", grant_ch, 0);
            chk("rst_done", granule_done, 0);
            chk("rst_data", in_overlap_pcmSample, 0);
            chk("rst_tag", in_overlap_firstSequence, 0);
            mcnt[0] = 0; mcnt[1] = 0;
            m_idx = 0; mcur = 0; mlast = 1; gran = 0; beats = 0; done_seen = 0;
            last_end = -1; first_cyc = 0; done_pend = 0; hold_pend = 0;
            ord.delete();
            ftag.delete();
        end else begin
            chk("granule_done", granule_done, done_pend);
            done_pend = 0;
            if (granule_done) done_seen++;
            if (m_idx != 0) begin
                chk("busy_mid", busy, 1);
                chk("grant_mid", grant_ch, mcur[0]);
                chk("other_ready", (mcur == 1) ? ch0_ready : ch1_ready, 0);
            end
            if (hold_pend) begin
                chk("hold_valid", in_overlap_valid, 1);
                chk("hold_data", in_overlap_pcmSample, held_d);
                chk("hold_tag", in_overlap_firstSequence, held_t);
                hold_pend = 0;
            end
            if (in_overlap_valid && in_overlap_ready) begin
                if (m_idx == 0) begin
                    a0 = en[0] && (mcnt[0] < lim[0]);
                    a1 = en[1] && (mcnt[1] < lim[1]);
                    if (!a0 && !a1) chk("unexpected_beat", 1, 0);
                    if (a0 && a1) mcur = 1 - mlast;
                    else mcur = a1 ? 1 : 0;
                    if (chk_gap && last_end >= 0) chk("idle_gap", cyc - last_end, 3);
                    first_cyc = cyc;
                    ord.push_back(mcur + 1);
                    ftag.push_back(int'(in_overlap_firstSequence));
                end
                et[1] = mcur[0];
                et[0] = (m_idx == 0);
                chk("data", in_overlap_pcmSample, data_fn(mcur, mcnt[mcur]));
                chk("tag", in_overlap_firstSequence, et);
                mcnt[mcur]++;
                m_idx++;
                beats++;
                if (m_idx == GL) begin
                    if (chk_tput) chk("throughput", cyc - first_cyc, GL - 1);
                    m_idx = 0;
                    mlast = mcur;
                    done_pend = 1;
                    last_end = cyc;
                    gran++;
                end
            end else if (in_overlap_valid) begin
                hold_pend = 1;
                held_d = in_overlap_pcmSample;
                held_t = in_overlap_firstSequence;
            end
        end
    end

    task automatic do_reset(input bit e0, input bit e1, input int l0, input int l1,
                            input int mode, input bit gap, input bit tput);
        @(posedge clk);
        #2;
        reset = 1'b0;
        en[0] = e0; en[1] = e1;
        lim[0] = l0; lim[1] = l1;
        rdy_mode = mode;
        chk_gap = gap;
        chk_tput = tput;
        drop_req = 0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    task automatic wait_gran(input int n, input int budget);
        for (int i = 0; i < budget && gran < n; i++) @(posedge clk);
        chk("wait_granules", gran >= n, 1);
        repeat (6) @(posedge clk);
        #2;
    endtask

    initial begin
        en[0] = 0; en[1] = 0; lim[0] = 0; lim[1] = 0;
        rdy_mode = 0; chk_gap = 0; chk_tput = 0; drop_req = 0;
        repeat (3) @(posedge clk);

        // Single ch0 granule, ready always high.
        do_reset(1, 0, GL, 0, 0, 1, 1);
        wait_gran(1, 2000);
        chk("t1_beats", beats, 576);
        chk("t1_done_pulses", done_seen, 1);
        chk("t1_order", code_of(ord), 1);
        chk("t1_first_tag", code_of(ftag), 1);
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_valid", in_overlap_valid, 0);

        // Both channels valid from reset: ch0, ch1, ch0.
        do_reset(1, 1, 2 * GL, GL, 0, 1, 1);
        wait_gran(3, 4000);
        chk("t2_order", code_of(ord), 121);
        chk("t2_first_tags", code_of(ftag), 131);
        chk("t2_done_pulses", done_seen, 3);

        // ch1 arrives mid ch0 granule and must wait its turn.
        do_reset(1, 0, GL, GL, 0, 1, 1);
        for (int i = 0; i < 1000 && mcnt[0] < 100; i++) @(posedge clk);
        #2;
        chk("t3_reach100", mcnt[0] >= 100, 1);
        en[1] = 1;
        wait_gran(2, 3000);
        chk("t3_order", code_of(ord), 12);
        chk("t3_first_tags", code_of(ftag), 13);

        // Consumer ready toggling 1010.
        do_reset(1, 0, GL, 0, 1, 0, 0);
        wait_gran(1, 3000);
        chk("t4_beats", beats, 576);
        chk("t4_done_pulses", done_seen, 1);

        // 3 ch0 + 2 ch1 granules with one 5-cycle ch0 valid gap.
        do_reset(1, 1, 3 * GL, 2 * GL, 0, 1, 0);
        for (int i = 0; i < 1000 && mcnt[0] < 200; i++) @(posedge clk);
        #2;
        chk("t5_reach200", mcnt[0] >= 200, 1);
        drop_req = 1;
        wait_gran(5, 6000);
        chk("t5_order", code_of(ord), 12121);
        chk("t5_beats", beats, 5 * 576);
`ifdef OVERLAP_SCHED_STATS_EN
        chk("stat_gran_ch0", stat_gran_ch0, 3);
        chk("stat_gran_ch1", stat_gran_ch1, 2);
        chk("stat_stall", stat_stall, 5);
`endif

        // Reset at ch1 sample 300, then ch0 must win the next arbitration.
        do_reset(1, 1, GL, 2 * GL, 0, 1, 1);
        for (int i = 0; i < 2000 && !(gran >= 1 && m_idx >= 300); i++) @(posedge clk);
        #2;
        chk("t6_reach300", (gran >= 1 && m_idx >= 300), 1);
        chk("t6_mid_channel", mcur, 1);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        wait_gran(1, 2000);
        chk("t6_order_after_reset", ord.size() > 0 ? ord[0] : 0, 1);
        chk("t6_first_tag", ftag.size() > 0 ? ftag[0] : 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
